// File: rtl/bp_be_fp_int_move_if.sv
// bp_be_fp_int_move_if: valid/ready bundle for the FP-to-integer move stage
interface bp_be_fp_int_move_if #(
  parameter int dword_width_p = 64,
  parameter int tag_width_p   = 5
);
  logic                     in_v_i;
  logic                     in_ready_o;
  logic [dword_width_p-1:0] in_raw_i;
  logic [1:0]               in_op_i;
  logic [tag_width_p-1:0]   in_tag_i;
  logic                     out_v_o;
  logic                     out_ready_i;
  logic [dword_width_p-1:0] out_data_o;
  logic [tag_width_p-1:0]   out_tag_o;
  modport master (
    output in_v_i, in_raw_i, in_op_i, in_tag_i, out_ready_i,
    input  in_ready_o, out_v_o, out_data_o, out_tag_o
  );
  modport slave (
    input  in_v_i, in_raw_i, in_op_i, in_tag_i, out_ready_i,
    output in_ready_o, out_v_o, out_data_o, out_tag_o
  );
endinterface

// File: rtl/bp_be_fp_int_move.sv
// bp_be_fp_int_move: FMV.X.W/FMV.X.D/FCLASS stage with a one-entry skid buffer
module bp_be_fp_int_move #(
  parameter int dword_width_p = 64,
  parameter int tag_width_p   = 5
) (
  input logic clk_i,
  input logic reset_n_i,
  input logic flush_i,
  bp_be_fp_int_move_if.slave io
);
  logic                     dp, sgn, e_one, e_zero, f_zero, f_msb;
  logic [9:0]               cls;
  logic [dword_width_p-1:0] result, skid_data;
  logic [tag_width_p-1:0]   skid_tag;
  logic                     skid_v, xfer, drain;
  always_comb begin
    dp     = io.in_op_i[0];
    sgn    = dp ? io.in_raw_i[63] : io.in_raw_i[31];
    e_one  = dp ? &io.in_raw_i[62:52] : &io.in_raw_i[30:23];
    e_zero = dp ? ~|io.in_raw_i[62:52] : ~|io.in_raw_i[30:23];
    f_zero = dp ? ~|io.in_raw_i[51:0] : ~|io.in_raw_i[22:0];
    f_msb  = dp ? io.in_raw_i[51] : io.in_raw_i[22];
    cls[0] = sgn & e_one & f_zero;
    cls[1] = sgn & ~e_one & ~e_zero;
    cls[2] = sgn & e_zero & ~f_zero;
    cls[3] = sgn & e_zero & f_zero;
    cls[4] = ~sgn & e_zero & f_zero;
    cls[5] = ~sgn & e_zero & ~f_zero;
    cls[6] = ~sgn & ~e_one & ~e_zero;
    cls[7] = ~sgn & e_one & f_zero;
    cls[8] = e_one & ~f_zero & ~f_msb;
    cls[9] = e_one & ~f_zero & f_msb;
    result = io.in_op_i[1] ? {{(dword_width_p-10){1'b0}}, cls}
           : dp ? io.in_raw_i : {{32{io.in_raw_i[31]}}, io.in_raw_i[31:0]};
  end
  assign io.in_ready_o = ~skid_v;
  assign xfer  = io.in_v_i & ~skid_v;
  assign drain = io.out_v_o & io.out_ready_i;
  // Data registers load only alongside a valid bit, so held outputs stay stable under stall
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      io.out_v_o    <= 1'b0;
      io.out_data_o <= '0;
      io.out_tag_o  <= '0;
      skid_v        <= 1'b0;
      skid_data     <= '0;
      skid_tag      <= '0;
    end else if (flush_i) begin
      io.out_v_o <= 1'b0;
      skid_v     <= 1'b0;
    end else begin
      if (!io.out_v_o || drain) begin
        io.out_v_o <= skid_v | xfer;
        if (skid_v) begin
          io.out_data_o <= skid_data;
          io.out_tag_o  <= skid_tag;
        end else if (xfer) begin
          io.out_data_o <= result;
          io.out_tag_o  <= io.in_tag_i;
        end
      end
      if (skid_v && drain) skid_v <= 1'b0;
      else if (xfer && io.out_v_o && !drain) begin
        skid_v    <= 1'b1;
        skid_data <= result;
        skid_tag  <= io.in_tag_i;
      end
    end
  end
endmodule
